// File: rtl/matmul_controller.sv
// Matrix-multiply sequencer: computes C = A x B on the register file
// using one MAC, one C element per pass (row read, column read, MAC, write).
module matmul_controller #(
    parameter int size          = 4,
    parameter int address_width = 4,
    parameter int cell_width    = 32,
    localparam int width        = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic                     in_start,
    input  logic [width-1:0]         in_rf_data,
    output logic [address_width-1:0] out_rf_address,
    output logic [width-1:0]         out_rf_data,
    output logic [1:0]               out_rf_type,
    output logic [1:0]               out_rf_select,
    output logic                     out_rf_read_en,
    output logic                     out_rf_write_en,
    output logic                     out_busy,
    output logic                     out_done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ROW,
        RD_COL,
        LATCH_COL,
        MAC,
        WRITE,
        DONE
    } state_t;

    localparam logic [address_width-1:0] LAST = address_width'(size - 1);

    localparam logic [1:0] T_CELL = 2'b00;
    localparam logic [1:0] T_ROW  = 2'b01;
    localparam logic [1:0] T_COL  = 2'b10;
    localparam logic [1:0] S_A    = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_C    = 2'b10;

    state_t                   r_state;
    logic [address_width-1:0] r_i;
    logic [address_width-1:0] r_j;
    logic [address_width-1:0] r_k;
    logic [cell_width-1:0]    r_acc;
    logic [width-1:0]         r_row;
    logic [width-1:0]         r_col;

    logic [cell_width-1:0]    w_a;
    logic [cell_width-1:0]    w_b;
    logic [cell_width-1:0]    w_prod;
    logic [cell_width-1:0]    w_acc_nxt;
    logic [address_width-1:0] w_i_nxt;
    logic [address_width-1:0] w_j_nxt;
    logic [address_width-1:0] w_wr_addr;
    logic [address_width-1:0] w_row_addr;
    logic                     w_last_elem;

    // Product and sum both wrap modulo 2^cell_width.
    always_comb begin
        w_a       = r_row[r_k*cell_width +: cell_width];
        w_b       = r_col[r_k*cell_width +: cell_width];
        w_prod    = w_a * w_b;
        w_acc_nxt = r_acc + w_prod;
    end

    always_comb begin
        w_last_elem = (r_i == LAST) && (r_j == LAST);
        w_j_nxt     = (r_j == LAST) ? '0 : r_j + 1'b1;
        w_i_nxt     = (r_j == LAST) ? r_i + 1'b1 : r_i;
        w_wr_addr   = address_width'(r_i * size + r_j);
        w_row_addr  = address_width'(w_i_nxt * size);
    end

    // Outputs are registered for the state being entered.
    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            r_state         <= IDLE;
            r_i             <= '0;
            r_j             <= '0;
            r_k             <= '0;
            r_acc           <= '0;
            r_row           <= '0;
            r_col           <= '0;
            out_rf_address  <= '0;
            out_rf_data     <= '0;
            out_rf_type     <= '0;
            out_rf_select   <= '0;
            out_rf_read_en  <= 1'b0;
            out_rf_write_en <= 1'b0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
        end else begin
            out_rf_address  <= '0;
            out_rf_data     <= '0;
            out_rf_type     <= '0;
            out_rf_select   <= '0;
            out_rf_read_en  <= 1'b0;
            out_rf_write_en <= 1'b0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (in_start) begin
                        r_i            <= '0;
                        r_j            <= '0;
                        r_state        <= RD_ROW;
                        out_rf_read_en <= 1'b1;
                        out_rf_type    <= T_ROW;
                        out_rf_select  <= S_A;
                        out_busy       <= 1'b1;
                    end
                end
                RD_ROW: begin
                    r_state        <= RD_COL;
                    out_rf_read_en <= 1'b1;
                    out_rf_type    <= T_COL;
                    out_rf_select  <= S_B;
                    out_rf_address <= r_j;
                    out_busy       <= 1'b1;
                end
                RD_COL: begin
                    r_row    <= in_rf_data;
                    r_state  <= LATCH_COL;
                    out_busy <= 1'b1;
                end
                LATCH_COL: begin
                    r_col    <= in_rf_data;
                    r_acc    <= '0;
                    r_k      <= '0;
                    r_state  <= MAC;
                    out_busy <= 1'b1;
                end
                MAC: begin
                    r_acc    <= w_acc_nxt;
                    r_k      <= r_k + 1'b1;
                    out_busy <= 1'b1;
                    if (r_k == LAST) begin
                        r_state         <= WRITE;
                        out_rf_write_en <= 1'b1;
                        out_rf_type     <= T_CELL;
                        out_rf_select   <= S_C;
                        out_rf_address  <= w_wr_addr;
                        out_rf_data     <= width'(w_acc_nxt);
                    end
                end
                WRITE: begin
                    r_i <= w_i_nxt;
                    r_j <= w_j_nxt;
                    if (w_last_elem) begin
                        r_state  <= DONE;
                        out_done <= 1'b1;
                    end else begin
                        r_state        <= RD_ROW;
                        out_rf_read_en <= 1'b1;
                        out_rf_type    <= T_ROW;
                        out_rf_select  <= S_A;
                        out_rf_address <= w_row_addr;
                        out_busy       <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_controller.sv
// Directed bench for matmul_controller: size=2 and size=3 instances,
// each on a behavioural 1-cycle-latency register file.
module tb_matmul_controller;

    logic clk;
    logic rst_n;
    logic st2;
    logic st3;

    logic [63:0] rdat2;
    logic [3:0]  adr2;
    logic [63:0] wdat2;
    logic [1:0]  typ2;
    logic [1:0]  sel2;
    logic        rd2;
    logic        wr2;
    logic        bsy2;
    logic        dn2;

    logic [95:0] rdat3;
    logic [3:0]  adr3;
    logic [95:0] wdat3;
    logic [1:0]  typ3;
    logic [1:0]  sel3;
    logic        rd3;
    logic        wr3;
    logic        bsy3;
    logic        dn3;

    int checks = 0;
    int errors = 0;
    int perr2  = 0;
    int perr3  = 0;

    logic [31:0] a2[4];
    logic [31:0] b2[4];
    logic [31:0] c2[4];
    logic [31:0] a3[9];
    logic [31:0] b3[9];
    logic [31:0] c3[9];
    int          wlog2[$];

    matmul_controller #(
        .size(2),
        .address_width(4),
        .cell_width(32)
    ) u_dut2 (
        .in_clk(clk),
        .in_reset(rst_n),
        .in_start(st2),
        .in_rf_data(rdat2),
        .out_rf_address(adr2),
        .out_rf_data(wdat2),
        .out_rf_type(typ2),
        .out_rf_select(sel2),
        .out_rf_read_en(rd2),
        .out_rf_write_en(wr2),
        .out_busy(bsy2),
        .out_done(dn2)
    );

    matmul_controller #(
        .size(3),
        .address_width(4),
        .cell_width(32)
    ) u_dut3 (
        .in_clk(clk),
        .in_reset(rst_n),
        .in_start(st3),
        .in_rf_data(rdat3),
        .out_rf_address(adr3),
        .out_rf_data(wdat3),
        .out_rf_type(typ3),
        .out_rf_select(sel3),
        .out_rf_read_en(rd3),
        .out_rf_write_en(wr3),
        .out_busy(bsy3),
        .out_done(dn3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Idle bus carries a junk pattern so stray sampling shows up in C.
    always @(posedge clk) begin : rf2
        logic [63:0] v;
        int          idx;
        v = {8{8'hA5}};
        if (rd2 && wr2) perr2++;
        if (sel2 == 2'b11) perr2++;
        if (rd2) begin
            if (!((typ2 == 2'b01 && sel2 == 2'b00) ||
                  (typ2 == 2'b10 && sel2 == 2'b01))) perr2++;
            for (int t = 0; t < 2; t++) begin
                if (typ2 == 2'b01) idx = (int'(adr2) / 2) * 2 + t;
                else idx = t * 2 + int'(adr2) % 2;
                v[t*32 +: 32] = (sel2 == 2'b00) ? a2[idx] : b2[idx];
            end
        end
        rdat2 <= v;
        if (wr2) begin
            if (typ2 != 2'b00 || sel2 != 2'b10) perr2++;
            if (wdat2[63:32] != 32'h0) perr2++;
            c2[adr2[1:0]] <= wdat2[31:0];
            wlog2.push_back(int'(adr2));
        end
    end

    always @(posedge clk) begin : rf3
        logic [95:0] v;
        int          idx;
        v = {12{8'hA5}};
        if (rd3 && wr3) perr3++;
        if (sel3 == 2'b11) perr3++;
        if (rd3) begin
            if (!((typ3 == 2'b01 && sel3 == 2'b00) ||
                  (typ3 == 2'b10 && sel3 == 2'b01))) perr3++;
            for (int t = 0; t < 3; t++) begin
                if (typ3 == 2'b01) idx = (int'(adr3) / 3) * 3 + t;
                else idx = t * 3 + int'(adr3) % 3;
                v[t*32 +: 32] = (sel3 == 2'b00) ? a3[idx] : b3[idx];
            end
        end
        rdat3 <= v;
        if (wr3) begin
            if (typ3 != 2'b00 || sel3 != 2'b10) perr3++;
            if (wdat3[95:32] != 64'h0) perr3++;
            if (adr3 < 4'd9) c3[adr3] <= wdat3[31:0];
            else perr3++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_c2(input string tag, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] e3);
        chk({tag, "_c00"}, 64'(c2[0]), 64'(e0));
        chk({tag, "_c01"}, 64'(c2[1]), 64'(e1));
        chk({tag, "_c10"}, 64'(c2[2]), 64'(e2));
        chk({tag, "_c11"}, 64'(c2[3]), 64'(e3));
    endtask

    task automatic chk_idle2(input string tag);
        chk({tag, "_ctl"}, 64'({rd2, wr2, bsy2, dn2, adr2, typ2, sel2}), 64'h0);
        chk({tag, "_data"}, wdat2, 64'h0);
    endtask

    task automatic run(input bit s3, input int pulse_at, input int rst_at,
                       input int lim, output int nd, output int nb,
                       output int dc);
        nd = 0;
        nb = 0;
        dc = 0;
        if (s3) st3 = 1'b1;
        else st2 = 1'b1;
        @(posedge clk);
        #1;
        st2 = 1'b0;
        st3 = 1'b0;
        for (int n = 1; n <= lim; n++) begin
            if (s3 ? bsy3 : bsy2) nb++;
            if (s3 ? dn3 : dn2) begin
                dc++;
                if (nd == 0) nd = n;
            end
            if (n == pulse_at) begin
                if (s3) st3 = 1'b1;
                else st2 = 1'b1;
            end else begin
                st2 = 1'b0;
                st3 = 1'b0;
            end
            if (n == rst_at) rst_n = 1'b0;
            @(posedge clk);
            #1;
        end
        st2 = 1'b0;
        st3 = 1'b0;
    endtask

    initial begin
        int nd;
        int nb;
        int dc;
        int base;
        rst_n = 1'b0;
        st2   = 1'b0;
        st3   = 1'b0;
        a2 = '{default: 32'h0};
        b2 = '{default: 32'h0};
        a3 = '{default: 32'h1};
        b3 = '{default: 32'h1};
        repeat (3) @(posedge clk);
        #1;
        chk_idle2("reset");
        chk("reset3_ctl", 64'({rd3, wr3, bsy3, dn3, adr3, typ3, sel3}), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // identity times B
        a2 = '{32'd1, 32'd0, 32'd0, 32'd1};
        b2 = '{32'd1, 32'd2, 32'd3, 32'd4};
        run(1'b0, 0, 0, 40, nd, nb, dc);
        chk("t1_done_at", 64'(nd), 64'd25);
        chk("t1_busy_cyc", 64'(nb), 64'd24);
        chk("t1_done_cnt", 64'(dc), 64'd1);
        chk_c2("t1", 32'd1, 32'd2, 32'd3, 32'd4);

        a2 = '{32'd1, 32'd2, 32'd3, 32'd4};
        b2 = '{32'd5, 32'd6, 32'd7, 32'd8};
        base = wlog2.size();
        run(1'b0, 0, 0, 40, nd, nb, dc);
        chk("t2_done_at", 64'(nd), 64'd25);
        chk_c2("t2", 32'd19, 32'd22, 32'd43, 32'd50);
        chk("t2_nwr", 64'(wlog2.size() - base), 64'd4);
        for (int t = 0; t < 4; t++)
            if (base + t < wlog2.size())
                chk("t2_wr_addr", 64'(wlog2[base+t]), 64'(t));

        // FFFFFFFF*2 -> FFFFFFFE, +1*1 -> FFFFFFFF
        a2 = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        b2 = '{32'd2, 32'd0, 32'd1, 32'd0};
        run(1'b0, 0, 0, 40, nd, nb, dc);
        chk_c2("t3", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);

        // sum wraps to 0; products 2*2^31 and (2^32-1)*2^31 wrap
        a2 = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd0};
        b2 = '{32'd1, 32'h8000_0000, 32'd1, 32'd0};
        run(1'b0, 0, 0, 40, nd, nb, dc);
        chk_c2("t3w", 32'd0, 32'h8000_0000, 32'd2, 32'd0);

        a2 = '{32'd1, 32'd2, 32'd3, 32'd4};
        b2 = '{32'd5, 32'd6, 32'd7, 32'd8};
        run(1'b0, 5, 0, 40, nd, nb, dc);
        chk("t4_done_at", 64'(nd), 64'd25);
        chk("t4_done_cnt", 64'(dc), 64'd1);
        chk("t4_busy_cyc", 64'(nb), 64'd24);
        chk_c2("t4", 32'd19, 32'd22, 32'd43, 32'd50);

        // cycle 16 is the first MAC of C[1][0]
        a2 = '{32'd2, 32'd1, 32'd1, 32'd2};
        b2 = '{32'd3, 32'd1, 32'd1, 32'd3};
        base = wlog2.size();
        run(1'b0, 0, 16, 30, nd, nb, dc);
        chk("t5_done_cnt", 64'(dc), 64'd0);
        chk("t5_nwr", 64'(wlog2.size() - base), 64'd2);
        chk_idle2("t5_abort");
        chk("t5_c00", 64'(c2[0]), 64'd7);
        chk("t5_c01", 64'(c2[1]), 64'd5);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(1'b0, 0, 0, 40, nd, nb, dc);
        chk("t5_done_at", 64'(nd), 64'd25);
        chk_c2("t5", 32'd7, 32'd5, 32'd5, 32'd7);

        run(1'b1, 0, 0, 80, nd, nb, dc);
        chk("t6_done_at", 64'(nd), 64'd64);
        chk("t6_busy_cyc", 64'(nb), 64'd63);
        chk("t6_done_cnt", 64'(dc), 64'd1);
        for (int t = 0; t < 9; t++)
            chk("t6_cell", 64'(c3[t]), 64'd3);

        chk("proto2", 64'(perr2), 64'd0);
        chk("proto3", 64'(perr3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
